// File: rtl/uart_cmd_ctrl_if.sv
// Purpose : bundles the receiver-side byte pair and the register-write command outputs.
// Latency : n/a (signal bundle only).
// Backpr. : none; all outputs are single-cycle pulses or held values.
// Ports   : rx_int/rx_data come from the UART receiver; cmd_valid/cmd_addr/cmd_data go to the
//           register bank; err_chk/err_timeout/busy are status. The controller uses the slave
//           modport and the byte source uses the master modport.
interface uart_cmd_ctrl_if;
  logic        rx_int;
  logic [7:0]  rx_data;
  logic        cmd_valid;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        err_chk;
  logic        err_timeout;
  logic        busy;

  modport slave (
    input  rx_int, rx_data,
    output cmd_valid, cmd_addr, cmd_data, err_chk, err_timeout, busy
  );

  modport master (
    output rx_int, rx_data,
    input  cmd_valid, cmd_addr, cmd_data, err_chk, err_timeout, busy
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Purpose : assembles 5-byte UART command frames (header, addr, data hi, data lo, checksum)
//           into single-cycle register-write commands; drops bad or stalled frames.
// Latency : cmd_valid/err_chk are registered two edges after rx_int_d captures the
//           checksum byte's falling edge (byte_stb stage, then output register).
// Backpr. : none; the register bank must take the cmd_valid pulse when it occurs.
// Ports   : clk, rst_n (async active-low); bus (slave modport of uart_cmd_ctrl_if).
//           Optional macro UART_CMD_STAT_EN adds ok_cnt[7:0] and err_cnt[7:0] outputs.
module uart_cmd_ctrl #(
  parameter logic [7:0]      HEADER      = 8'hAA,
  parameter int unsigned     TO_W        = 20,
  parameter logic [TO_W-1:0] TIMEOUT_CYC = 20'd100000
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_cmd_ctrl_if.slave  bus
`ifdef UART_CMD_STAT_EN
  ,
  output logic [7:0]      ok_cnt,
  output logic [7:0]      err_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DHI,
    DLO,
    CHK
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYC - TO_W'(1);

  state_t      state, state_nx;
  logic        rx_int_d;
  logic        fall;
  logic        byte_stb;
  logic [TO_W-1:0] to_cnt;
  logic [7:0]  addr_t, dhi_t, dlo_t;
  logic [7:0]  sum;
  logic        ld_addr, ld_dhi, ld_dlo;
  logic        valid_nx, chk_nx, to_nx;
  logic        cmd_valid_q, err_chk_q, err_to_q;
  logic [7:0]  cmd_addr_q;
  logic [15:0] cmd_data_q;

  // Byte completion is the falling edge of rx_int; byte_stb lags it by one
  // cycle so the receiver's data register has settled before it is read.
  assign fall = rx_int_d & ~bus.rx_int;

  // Checksum is the 8-bit wrapped sum of the three payload bytes.
  assign sum = addr_t + dhi_t + dlo_t;

  always_comb begin
    state_nx = state;
    ld_addr  = 1'b0;
    ld_dhi   = 1'b0;
    ld_dlo   = 1'b0;
    valid_nx = 1'b0;
    chk_nx   = 1'b0;
    to_nx    = 1'b0;
    if (byte_stb) begin
      // A byte arriving on the terminal-count cycle takes priority over the timeout.
      case (state)
        IDLE: if (bus.rx_data == HEADER) state_nx = ADDR;
        ADDR: begin
          ld_addr  = 1'b1;
          state_nx = DHI;
        end
        DHI: begin
          ld_dhi   = 1'b1;
          state_nx = DLO;
        end
        DLO: begin
          ld_dlo   = 1'b1;
          state_nx = CHK;
        end
        CHK: begin
          if (bus.rx_data == sum) valid_nx = 1'b1;
          else                    chk_nx   = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end else if ((state != IDLE) && (to_cnt == TO_LAST)) begin
      state_nx = IDLE;
      to_nx    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rx_int_d    <= 1'b0;
      byte_stb    <= 1'b0;
      to_cnt      <= '0;
      addr_t      <= 8'h00;
      dhi_t       <= 8'h00;
      dlo_t       <= 8'h00;
      cmd_valid_q <= 1'b0;
      err_chk_q   <= 1'b0;
      err_to_q    <= 1'b0;
      cmd_addr_q  <= 8'h00;
      cmd_data_q  <= 16'h0000;
    end else begin
      state    <= state_nx;
      rx_int_d <= bus.rx_int;
      byte_stb <= fall;
      // Inter-byte timer only runs while a frame is open.
      if (byte_stb || (state == IDLE)) to_cnt <= '0;
      else                             to_cnt <= to_cnt + TO_W'(1);
      if (ld_addr) addr_t <= bus.rx_data;
      if (ld_dhi)  dhi_t  <= bus.rx_data;
      if (ld_dlo)  dlo_t  <= bus.rx_data;
      cmd_valid_q <= valid_nx;
      err_chk_q   <= chk_nx;
      err_to_q    <= to_nx;
      if (valid_nx) begin
        cmd_addr_q <= addr_t;
        cmd_data_q <= {dhi_t, dlo_t};
      end
    end
  end

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_addr    = cmd_addr_q;
  assign bus.cmd_data    = cmd_data_q;
  assign bus.err_chk     = err_chk_q;
  assign bus.err_timeout = err_to_q;
  assign bus.busy        = (state != IDLE);

`ifdef UART_CMD_STAT_EN
  // Frame statistics; both counters wrap naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_cnt  <= 8'h00;
      err_cnt <= 8'h00;
    end else begin
      if (cmd_valid_q)             ok_cnt  <= ok_cnt + 8'd1;
      if (err_chk_q || err_to_q)   err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Purpose : self-checking bench for uart_cmd_ctrl: frame table, hand-written corner
//           sequences and a random byte stream compared against a frame-level model.
// Ports   : none; instantiates uart_cmd_ctrl_if and the controller with a short timeout.
module tb_uart_cmd_ctrl;
  localparam int         T   = 40;
  localparam logic [7:0] HDR = 8'hAA;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_cmd_ctrl_if bus ();
`ifdef UART_CMD_STAT_EN
  logic [7:0] ok_cnt, err_cnt;
`endif

  uart_cmd_ctrl #(
    .HEADER(HDR),
    .TO_W(20),
    .TIMEOUT_CYC(20'(T))
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef UART_CMD_STAT_EN
    ,
    .ok_cnt(ok_cnt),
    .err_cnt(err_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_v = 0, n_e = 0, n_t = 0;

  typedef struct {
    int          kind;   // 0 = accepted, 1 = checksum error, 2 = timeout
    logic [7:0]  addr;
    logic [15:0] data;
  } ev_t;

  ev_t dut_q[$];
  ev_t exp_q[$];
  ev_t mon_ev;

  typedef struct {
    logic [39:0] bytes;
    logic        exp_v;
    logic        exp_e;
    logic [7:0]  exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else             n_pass = n_pass + 1;
  endtask

  // Output monitor: records every pulse as an event and checks exclusivity.
  always @(negedge clk) begin
    if (rst_n && (bus.cmd_valid || bus.err_chk || bus.err_timeout)) begin
      check("pulse_excl", 32'($countones({bus.cmd_valid, bus.err_chk, bus.err_timeout})), 32'd1);
      mon_ev.kind = bus.cmd_valid ? 0 : (bus.err_chk ? 1 : 2);
      mon_ev.addr = bus.cmd_addr;
      mon_ev.data = bus.cmd_data;
      dut_q.push_back(mon_ev);
      if (bus.cmd_valid)   n_v = n_v + 1;
      if (bus.err_chk)     n_e = n_e + 1;
      if (bus.err_timeout) n_t = n_t + 1;
    end
  end

  // Frame-level reference model: a list of received bytes with arrival times.
  logic [7:0]  fb[$];
  int          last_t = 0;
  logic [7:0]  h_addr = 8'h00;
  logic [15:0] h_data = 16'h0000;

  function automatic void push_exp(input int kind);
    ev_t e;
    e.kind = kind;
    e.addr = h_addr;
    e.data = h_data;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    fb.delete();
    h_addr = 8'h00;
    h_data = 16'h0000;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int t);
    logic [7:0] s;
    if ((fb.size() > 0) && ((t - last_t) > T)) begin
      push_exp(2);
      fb.delete();
    end
    if (fb.size() == 0) begin
      if (b == HDR) fb.push_back(b);
    end else begin
      fb.push_back(b);
      if (fb.size() == 5) begin
        s = fb[1] + fb[2] + fb[3];
        if (s == fb[4]) begin
          h_addr = fb[1];
          h_data = {fb[2], fb[3]};
          push_exp(0);
        end else begin
          push_exp(1);
        end
        fb.delete();
      end
    end
    last_t = t;
  endfunction

  function automatic void model_flush();
    if (fb.size() > 0) push_exp(2);
    fb.delete();
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Falling edge of rx_int lands exactly 'gap' cycles after the previous one (gap >= 2).
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_int = 1'b1;
    wait_cycles(gap - 1);
    bus.rx_data = b;
    bus.rx_int  = 1'b0;
    model_byte(b, cyc);
    wait_cycles(1);
  endtask

  task automatic send_frame(input logic [39:0] bytes, input int gap);
    for (int i = 0; i < 5; i++) send_byte(bytes[39-8*i -: 8], gap);
  endtask

  task automatic end_section(input string tag);
    wait_cycles(T + 10);
    model_flush();
    check({tag, "_nev"}, 32'(dut_q.size()), 32'(exp_q.size()));
    for (int i = 0; (i < dut_q.size()) && (i < exp_q.size()); i++) begin
      check({tag, "_kind"}, 32'(dut_q[i].kind), 32'(exp_q[i].kind));
      check({tag, "_addr"}, 32'(dut_q[i].addr), 32'(exp_q[i].addr));
      check({tag, "_data"}, 32'(dut_q[i].data), 32'(exp_q[i].data));
    end
    dut_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(bus.cmd_valid), 32'd0);
    check({tag, "_addr"},  32'(bus.cmd_addr), 32'd0);
    check({tag, "_data"},  32'(bus.cmd_data), 32'd0);
    check({tag, "_echk"},  32'(bus.err_chk), 32'd0);
    check({tag, "_eto"},   32'(bus.err_timeout), 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
  endtask

  function automatic int pick_gap();
    int g;
    g = int'($urandom_range(0, 24));
    case (g)
      0:       return T;
      1:       return T + 1;
      2:       return T - 1;
      3:       return 2 * T;
      default: return int'($urandom_range(2, 6));
    endcase
  endfunction

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v0, e0, t0, nb;
    logic [7:0]  a, dh, dl, s;
    logic [39:0] fr;

    vt[0] = '{40'hAA_12_34_56_9D, 1'b0, 1'b1, 8'h00, 16'h0000};
    vt[1] = '{40'hAA_12_34_56_9C, 1'b1, 1'b0, 8'h12, 16'h3456};
    vt[2] = '{40'hAA_FF_FF_03_01, 1'b1, 1'b0, 8'hFF, 16'hFF03};
    vt[3] = '{40'hAA_01_02_03_07, 1'b0, 1'b1, 8'hFF, 16'hFF03};
    vt[4] = '{40'hAA_80_40_20_E0, 1'b1, 1'b0, 8'h80, 16'h4020};

    bus.rx_int  = 1'b0;
    bus.rx_data = 8'h00;
    model_reset();
    wait_cycles(3);
    check_all_zero("rst");
    rst_n = 1'b1;
    wait_cycles(2);
    check_all_zero("post_rst");

    // Frame table
    for (int i = 0; i < 5; i++) begin
      v0 = n_v; e0 = n_e; t0 = n_t;
      send_frame(vt[i].bytes, 3);
      wait_cycles(6);
      check("tbl_valid_cnt", 32'(n_v - v0), 32'(vt[i].exp_v));
      check("tbl_chk_cnt",   32'(n_e - e0), 32'(vt[i].exp_e));
      check("tbl_to_cnt",    32'(n_t - t0), 32'd0);
      check("tbl_addr",      32'(bus.cmd_addr), 32'(vt[i].exp_addr));
      check("tbl_data",      32'(bus.cmd_data), 32'(vt[i].exp_data));
      check("tbl_busy",      32'(bus.busy), 32'd0);
    end
    end_section("table");

    // Garbage bytes ignored, then a frame
    send_byte(8'h00, 3);
    send_byte(8'hFF, 3);
    wait_cycles(3);
    check("garbage_busy", 32'(bus.busy), 32'd0);
    v0 = n_v;
    send_frame(40'hAA_01_00_02_03, 3);
    wait_cycles(4);
    check("garbage_valid_cnt", 32'(n_v - v0), 32'd1);
    check("garbage_addr", 32'(bus.cmd_addr), 32'h01);
    check("garbage_data", 32'(bus.cmd_data), 32'h0002);
    end_section("garbage");

    // Stalled frame times out once, then a fresh frame is accepted
    t0 = n_t;
    send_byte(HDR, 3);
    send_byte(8'h05, 3);
    wait_cycles(T + 10);
    check("to_pulse_cnt", 32'(n_t - t0), 32'd1);
    check("to_busy", 32'(bus.busy), 32'd0);
    send_frame(40'hAA_05_00_01_06, 3);
    wait_cycles(4);
    check("to_after_addr", 32'(bus.cmd_addr), 32'h05);
    check("to_after_data", 32'(bus.cmd_data), 32'h0001);
    end_section("timeout");

    // Bytes exactly on the terminal-count cycle keep the frame alive
    t0 = n_t; v0 = n_v;
    send_byte(HDR, 3);
    send_byte(8'h07, T);
    send_byte(8'h00, T);
    send_byte(8'h01, T);
    send_byte(8'h08, T);
    wait_cycles(4);
    check("tc_no_timeout", 32'(n_t - t0), 32'd0);
    check("tc_valid_cnt", 32'(n_v - v0), 32'd1);
    check("tc_addr", 32'(bus.cmd_addr), 32'h07);
    // One cycle later the frame is dropped
    t0 = n_t;
    send_byte(HDR, 3);
    send_byte(8'h09, 3);
    send_byte(8'h00, T + 1);
    send_byte(8'h01, 3);
    send_byte(8'h0A, 3);
    wait_cycles(4);
    check("tc1_timeout", 32'(n_t - t0), 32'd1);
    check("tc1_addr_kept", 32'(bus.cmd_addr), 32'h07);
    end_section("term_cnt");

    // Reset in the middle of a frame
    send_byte(HDR, 3);
    send_byte(8'h12, 3);
    wait_cycles(3);
    check("midrst_busy_before", 32'(bus.busy), 32'd1);
    end_section("midrst_pre");
    rst_n = 1'b0;
    model_reset();
    wait_cycles(2);
    check_all_zero("midrst");
    rst_n = 1'b1;
    wait_cycles(2);
    check("midrst_busy_after", 32'(bus.busy), 32'd0);
    send_frame(40'hAA_12_34_56_9C, 3);
    wait_cycles(4);
    check("midrst_addr", 32'(bus.cmd_addr), 32'h12);
    check("midrst_data", 32'(bus.cmd_data), 32'h3456);
    end_section("midrst");

    // Random stream against the model
    for (int f = 0; f < 80; f++) begin
      nb = int'($urandom_range(0, 9));
      a  = 8'($urandom);
      dh = 8'($urandom);
      dl = 8'($urandom);
      s  = a + dh + dl;
      if (nb == 0) s = s ^ (8'h01 << $urandom_range(0, 7));
      if (nb == 1) send_byte(8'($urandom), pick_gap());
      fr = {HDR, a, dh, dl, s};
      for (int i = 0; i < ((nb == 2) ? int'($urandom_range(1, 4)) : 5); i++)
        send_byte(fr[39-8*i -: 8], pick_gap());
    end
    end_section("random");

`ifdef UART_CMD_STAT_EN
    rst_n = 1'b0;
    model_reset();
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(2);
    check("stat_ok_rst", 32'(ok_cnt), 32'd0);
    check("stat_err_rst", 32'(err_cnt), 32'd0);
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      fr = {HDR, a, 8'h00, 8'h01, 8'(a + 8'h01)};
      send_frame(fr, 2);
      if (i == 0) begin
        wait_cycles(3);
        check("stat_ok_one", 32'(ok_cnt), 32'd1);
      end
    end
    wait_cycles(4);
    check("stat_ok_wrap", 32'(ok_cnt), 32'd0);
    check("stat_err_zero", 32'(err_cnt), 32'd0);
    send_frame(40'hAA_01_02_03_07, 2);
    wait_cycles(4);
    check("stat_err_one", 32'(err_cnt), 32'd1);
    end_section("stat");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
